// File: rtl/ifetch_prefetch_buffer.sv
// Sequential instruction prefetcher with an in-order response FIFO and redirect flush.
// Optional same-cycle response bypass to the fetch stage: define IFB_BYPASS_EN.
module ifetch_prefetch_buffer #(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        out_misaligned
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [31:0] NOP   = 32'd19;

    typedef enum logic [1:0] {FETCH, MIS_HOLD, MIS_DEAD} state_t;

    state_t             state;
    logic [31:0]        fetch_pc;
    logic [31:0]        tail_pc;
    logic [2:0]         outstanding;
    logic [2:0]         drop_cnt;
    logic [PTR_W:0]     count;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [31:0]        fifo_pc   [DEPTH];
    logic [31:0]        fifo_inst [DEPTH];

    logic               gnt;
    logic               accept;
    logic               bypass;
    logic               push;
    logic               pop;
    logic [31:0]        occupancy;

    // Reserving FIFO space for every in-flight request means a response can always be stored.
    assign occupancy = 32'(count) + 32'(outstanding);
    assign mem_req   = (state == FETCH) && !redirect
                       && (32'(outstanding) < MAX_OUTSTANDING) && (occupancy < DEPTH);
    assign mem_addr  = fetch_pc;
    assign gnt       = mem_req && mem_gnt;

    assign accept = mem_rvalid && (drop_cnt == '0) && (state == FETCH) && !redirect;

`ifdef IFB_BYPASS_EN
    assign bypass = accept && (count == '0) && out_ready;
`else
    assign bypass = 1'b0;
`endif

    assign push = accept && !bypass;
    assign pop  = (state == FETCH) && (count != '0) && out_ready && !redirect;

    always_comb begin
        out_valid      = 1'b0;
        out_pc         = tail_pc;
        out_inst       = NOP;
        out_misaligned = 1'b0;
        if (rst) begin
            case (state)
                FETCH: begin
                    if (count != '0) begin
                        out_valid = 1'b1;
                        out_pc    = fifo_pc[rd_ptr];
                        out_inst  = fifo_inst[rd_ptr];
                    end else if (bypass) begin
                        out_valid = 1'b1;
                        out_inst  = mem_rdata;
                    end
                end
                MIS_HOLD: begin
                    out_valid      = 1'b1;
                    out_misaligned = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]   <= tail_pc;
            fifo_inst[wr_ptr] <= mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= FETCH;
            fetch_pc    <= RESET_PC;
            tail_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            outstanding <= outstanding + 3'(gnt) - 3'(mem_rvalid);
            if (redirect) begin
                state    <= (redirect_pc[1:0] != 2'b00) ? MIS_HOLD : FETCH;
                fetch_pc <= redirect_pc;
                tail_pc  <= redirect_pc;
                // Responses already marked for dropping are a subset of outstanding, so every
                // request still pending after this edge becomes one to discard.
                drop_cnt <= outstanding - 3'(mem_rvalid);
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (gnt) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (mem_rvalid && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - 3'd1;
                end
                if (accept) begin
                    tail_pc <= tail_pc + 32'd4;
                end
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
                if ((state == MIS_HOLD) && out_ready) begin
                    state <= MIS_DEAD;
                end
            end
        end
    end

endmodule

// File: tb/tb_ifetch_prefetch_buffer.sv
// Scoreboard bench for ifetch_prefetch_buffer: random memory/fetch-stage traffic against
// a queue-based reference model of in-flight requests and expected fetch-stage entries.
module tb_ifetch_prefetch_buffer;
    localparam int          DEPTH    = 4;
    localparam int          MAX_OUT  = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    typedef enum {M_FETCH, M_HOLD, M_DEAD} mode_t;
    typedef struct { logic [31:0] addr; bit stale; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_misaligned;

    req_t        inflight[$];
    ent_t        exp_q[$];
    logic [31:0] mem_q[$];
    mode_t       m_mode   = M_FETCH;
    logic [31:0] m_fetch  = RESET_PC;
    bit          exp_req;
    bit          exp_valid;
    logic [31:0] exp_tail;
    bit          dut_gnt;
    logic [31:0] dut_addr;
    req_t        r;
    ent_t        e;
    bit          rRd;
    bit          rRst;
    logic [31:0] rPc;
    int          vectors     = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    ifetch_prefetch_buffer #(
        .DEPTH(DEPTH),
        .MAX_OUTSTANDING(MAX_OUT),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pc(out_pc),
        .out_inst(out_inst),
        .out_misaligned(out_misaligned)
    );

    // Memory contents are a fixed scramble of the address so every word is distinguishable.
    function automatic logic [31:0] instOf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drives one cycle of inputs, publishes what the model expects to see this cycle,
    // then advances the model and the memory across the clock edge.
    task automatic applyStimulus(input bit rstVal, input bit redir, input logic [31:0] rpc,
                                 input bit ready, input bit gnt, input bit rv);
        @(negedge clk);
        rst         = rstVal;
        redirect    = redir;
        redirect_pc = rpc;
        out_ready   = ready;
        mem_gnt     = gnt;
        mem_rvalid  = rv && rstVal && (mem_q.size() != 0);
        mem_rdata   = mem_rvalid ? instOf(mem_q[0]) : $urandom;

        exp_req   = (m_mode == M_FETCH) && !redir && (inflight.size() < MAX_OUT)
                    && ((exp_q.size() + inflight.size()) < DEPTH);
        exp_valid = rstVal && (((m_mode == M_FETCH) && (exp_q.size() != 0)) || (m_mode == M_HOLD));
        exp_tail  = m_fetch;
        for (int i = inflight.size() - 1; i >= 0; i--) begin
            if (!inflight[i].stale) exp_tail = inflight[i].addr;
        end

        @(posedge clk);
        #1;
        if (!rstVal) begin
            exp_q.delete();
            inflight.delete();
            mem_q.delete();
            m_fetch = RESET_PC;
            m_mode  = M_FETCH;
        end else begin
            if (mem_rvalid) begin
                void'(mem_q.pop_front());
                if (inflight.size() != 0) begin
                    r = inflight.pop_front();
                    if (!r.stale && !redir && (m_mode == M_FETCH)) begin
                        e.pc   = r.addr;
                        e.inst = instOf(r.addr);
                        exp_q.push_back(e);
                    end
                end
            end
            if (dut_gnt) mem_q.push_back(dut_addr);
            if (exp_req && gnt) begin
                r.addr  = m_fetch;
                r.stale = 1'b0;
                inflight.push_back(r);
                m_fetch = m_fetch + 32'd4;
            end
            if (redir) begin
                exp_q.delete();
                foreach (inflight[i]) inflight[i].stale = 1'b1;
                m_fetch = rpc;
                m_mode  = (rpc[1:0] != 2'b00) ? M_HOLD : M_FETCH;
            end else if ((m_mode == M_HOLD) && ready) begin
                m_mode = M_DEAD;
            end
        end
    endtask

    // Monitor: samples late in each cycle, pops the scoreboard on every fetch-stage handshake.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            dut_gnt  = rst && mem_req && mem_gnt;
            dut_addr = mem_addr;
            if (rst) begin
                checkOutput("mem_req", 32'(mem_req), 32'(exp_req));
                checkOutput("mem_addr", mem_addr, m_fetch);
            end
            checkOutput("out_valid", 32'(out_valid), 32'(exp_valid));
            if (!out_valid) begin
                checkOutput("idle_inst", out_inst, NOP);
                checkOutput("idle_misaligned", 32'(out_misaligned), 32'd0);
                if (rst) checkOutput("idle_pc", out_pc, exp_tail);
            end else if (m_mode == M_HOLD) begin
                checkOutput("hold_pc", out_pc, exp_tail);
                checkOutput("hold_inst", out_inst, NOP);
                checkOutput("hold_misaligned", 32'(out_misaligned), 32'd1);
            end else if (out_ready && !redirect) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_pop: got pc 0x%08h, expected no entry at %0t", out_pc, $time);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("head_pc", out_pc, e.pc);
                    checkOutput("head_inst", out_inst, e.inst);
                    checkOutput("head_misaligned", 32'(out_misaligned), 32'd0);
                end
            end
        end
    end

    initial begin
        rst         = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        out_ready   = 1'b0;
        mem_gnt     = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = 32'd0;

        $display("[TB] reset");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1);

        $display("[TB] streaming with single-cycle memory");
        for (int i = 0; i < 30; i++) applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1);

        $display("[TB] fetch stage stalled, then released");
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1);

        $display("[TB] redirect with requests in flight");
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h0000_0100, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1);

        $display("[TB] redirect, response and pop together");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 32'h0000_0300, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1);

        $display("[TB] misaligned target");
        applyStimulus(1'b1, 1'b1, 32'h0000_0102, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 32'h0000_0200, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1);

        $display("[TB] address wrap");
        applyStimulus(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1);

        $display("[TB] reset with a partly full queue");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1);

        $display("[TB] random traffic");
        for (int i = 0; i < 3000; i++) begin
            rRd  = ($urandom_range(99) < 6);
            rRst = ($urandom_range(299) != 0);
            rPc  = $urandom & 32'h0000_0FFC;
            if ($urandom_range(9) < 3) rPc = rPc | 32'($urandom_range(3, 1));
            applyStimulus(rRst, rRd, rPc, ($urandom_range(99) < 65),
                          ($urandom_range(99) < 70), ($urandom_range(99) < 60));
        end

        $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
